// File: rtl/rtype_instr_encoder.sv
// rtype_instr_encoder: assembles RV32I R-type instruction words from a one-hot
// ALU operation and register fields, and streams them out with sequential word
// addresses. Two registered stages: stage 1 encodes and legality-checks the
// request, stage 2 is the output register holding the word and its address.
//
// Handshake rules for both ports: a transfer happens on a rising edge where
// valid and ready are both 1. A producer holding valid=1 keeps its payload
// stable until the transfer; out_valid/out_instr/out_addr never change while
// out_valid=1 and out_ready=0. in_ready depends only on registered state,
// out_ready and rst, never on in_valid.
module rtype_instr_encoder #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int unsigned DEPTH     = 256,
   parameter int unsigned ERR_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_op,
   input  logic             in_alt,
   input  logic [4:0]       in_rd,
   input  logic [4:0]       in_rs1,
   input  logic [4:0]       in_rs2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_instr,
   output logic [31:0]      out_addr,
   output logic             err_pulse,
   output logic [ERR_W-1:0] err_count,
   output logic             wrapped
);

   localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [6:0]  OPCODE_OP = 7'b0110011;
   localparam logic [6:0]  FUNCT7_ALT = 7'b0100000;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

   // Encoder outputs for the request currently on the input port
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic        in_onehot;
   logic        in_alt_ok;
   logic        in_legal;
   logic [31:0] in_word;

   // Pipeline control
   logic        in_accept;
   logic        s1_advance;
   logic        s1_valid;
   logic [31:0] s1_word;

   // Address generator
   logic [31:0]      addr_q;
   logic [IDX_W-1:0] addr_idx;

   // Stage 1 can move forward whenever the output register is empty or draining
   assign s1_advance = !out_valid || out_ready;
   assign in_ready   = !rst && (!s1_valid || s1_advance);
   assign in_accept  = in_valid && in_ready;

   // Decode the one-hot op into funct3/funct7, judge legality and build the word
   always_comb begin
      in_funct3 = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (in_op[i]) begin
            in_funct3 = in_funct3 | 3'(i);
         end
      end
      in_onehot = (in_op != 8'h00) && ((in_op & (in_op - 8'd1)) == 8'h00);
      in_alt_ok = in_op[0] || in_op[5];
      in_legal  = in_onehot && !(in_alt && !in_alt_ok);
      in_funct7 = (in_alt && in_alt_ok) ? FUNCT7_ALT : 7'd0;
      in_word   = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OPCODE_OP};
   end

   // Stage 1 register: only legal requests become valid entries; illegal ones
   // complete the handshake and vanish here
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_word  <= 32'd0;
      end else if (in_accept) begin
         s1_valid <= in_legal;
         s1_word  <= in_word;
      end else if (s1_advance) begin
         s1_valid <= 1'b0;
      end
   end

   // Stage 2 register and address counter: reload on the same edge the old
   // word leaves, so a full stream has no bubbles
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_instr <= 32'd0;
         out_addr  <= BASE_ADDR;
         addr_q    <= BASE_ADDR;
         addr_idx  <= '0;
         wrapped   <= 1'b0;
      end else if (s1_advance) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_instr <= s1_word;
            out_addr  <= addr_q;
            if (addr_idx == LAST_IDX) begin
               addr_idx <= '0;
               addr_q   <= BASE_ADDR;
               wrapped  <= 1'b1;
            end else begin
               addr_idx <= addr_idx + 1'b1;
               addr_q   <= addr_q + 32'd4;
            end
         end
      end
   end

   // Illegal-request reporting: one-cycle pulse plus saturating count
   always_ff @(posedge clk) begin
      if (rst) begin
         err_pulse <= 1'b0;
         err_count <= '0;
      end else begin
         err_pulse <= in_accept && !in_legal;
         if (in_accept && !in_legal && (err_count != {ERR_W{1'b1}})) begin
            err_count <= err_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_rtype_instr_encoder.sv
// Bench for rtype_instr_encoder: directed vectors from the instruction format
// plus a randomized phase, all scored against a word-level reference model.
module tb_rtype_instr_encoder;

   localparam logic [31:0] BASE  = 32'h0000_1000;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned ERR_W = 3;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       in_op;
   logic             in_alt;
   logic [4:0]       in_rd;
   logic [4:0]       in_rs1;
   logic [4:0]       in_rs2;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_instr;
   logic [31:0]      out_addr;
   logic             err_pulse;
   logic [ERR_W-1:0] err_count;
   logic             wrapped;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q[$];  // {addr, instr} in emission order
   int  acc_cnt  = 0;      // legal words accepted since reset
   int  popped   = 0;      // words transferred out since reset
   bit  pend_err = 0;
   bit  held     = 0;
   bit  rand_mode = 0;

   rtype_instr_encoder #(
      .BASE_ADDR (BASE),
      .DEPTH     (DEPTH),
      .ERR_W     (ERR_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .in_alt    (in_alt),
      .in_rd     (in_rd),
      .in_rs1    (in_rs1),
      .in_rs2    (in_rs2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_instr (out_instr),
      .out_addr  (out_addr),
      .err_pulse (err_pulse),
      .err_count (err_count),
      .wrapped   (wrapped)
   );

   // ---------------- clock and watchdog ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic int m_index(input logic [7:0] op);
      int idx = -1;
      for (int b = 0; b < 8; b++) begin
         if (op == (8'd1 << b)) idx = b;
      end
      return idx;
   endfunction

   function automatic bit m_legal(input logic [7:0] op, input logic alt);
      int f = m_index(op);
      if (f < 0) return 1'b0;
      return !alt || (f == 0) || (f == 5);
   endfunction

   function automatic logic [31:0] m_word(input logic [7:0] op, input logic alt,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
      int unsigned f3 = int'(m_index(op));
      int unsigned f7 = (alt && (f3 == 0 || f3 == 5)) ? 32 : 0;
      int unsigned w;
      w = f7 * 33554432 + int'(rs2) * 1048576 + int'(rs1) * 32768
        + f3 * 4096 + int'(rd) * 128 + 51;
      return 32'(w);
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard monitor ----------------
   // Sampled on the falling edge, halfway between input changes and the active edge
   always @(negedge clk) begin
      if (rst) begin
         pend_err = 1'b0;
         held     = 1'b0;
      end else begin
         bit exp_wrap;
         check("err_pulse", 64'(err_pulse), 64'(pend_err));
         if (held) check("hold_valid", 64'(out_valid), 64'd1);
         exp_wrap = (popped + int'(out_valid)) >= int'(DEPTH);
         check("wrapped", 64'(wrapped), 64'(exp_wrap));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
               check("out_word", {out_addr, out_instr}, exp_q[0]);
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  popped++;
               end
            end
         end
         held     = out_valid && !out_ready;
         pend_err = in_valid && in_ready && !m_legal(in_op, in_alt);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_req(input logic [7:0] op, input logic alt, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
      in_valid = 1'b1;
      in_op    = op;
      in_alt   = alt;
      in_rd    = rd;
      in_rs1   = rs1;
      in_rs2   = rs2;
   endtask

   task automatic wait_accept();
      bit accepted = 1'b0;
      for (int n = 0; n < 50 && !accepted; n++) begin
         @(negedge clk);
         if (in_ready) begin
            accepted = 1'b1;
            if (m_legal(in_op, in_alt)) begin
               exp_q.push_back({BASE + 32'(4 * (acc_cnt % int'(DEPTH))),
                                m_word(in_op, in_alt, in_rd, in_rs1, in_rs2)});
               acc_cnt++;
            end
         end
         @(posedge clk);
         #1;
         if (rand_mode) out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = 1'b0;
      check("accept_timeout", 64'(accepted), 64'd1);
   endtask

   task automatic send(input logic [7:0] op, input logic alt, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
      drive_req(op, alt, rd, rs1, rs2);
      wait_accept();
   endtask

   task automatic send_legal();
      int f = $urandom_range(0, 7);
      logic alt = (f == 0 || f == 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      send(8'd1 << f, alt, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)));
   endtask

   task automatic send_illegal();
      int kind = $urandom_range(0, 2);
      int a = $urandom_range(0, 7);
      int b = (a + $urandom_range(1, 7)) % 8;
      int f = $urandom_range(1, 6);
      logic [7:0] op;
      logic alt = 1'($urandom_range(0, 1));
      if (f >= 5) f++;
      case (kind)
         0: op = 8'h00;
         1: op = (8'd1 << a) | (8'd1 << b);
         default: begin op = 8'd1 << f; alt = 1'b1; end
      endcase
      send(op, alt, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)));
   endtask

   task automatic drain();
      rand_mode = 1'b0;
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int n = 0; n < 50 && exp_q.size() != 0; n++) begin
         @(posedge clk);
         #1;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      rand_mode = 1'b0;
      @(posedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_instr", 64'(out_instr), 64'd0);
      check("rst_out_addr", 64'(out_addr), 64'(BASE));
      check("rst_err_pulse", 64'(err_pulse), 64'd0);
      check("rst_err_count", 64'(err_count), 64'd0);
      check("rst_wrapped", 64'(wrapped), 64'd0);
      @(posedge clk);
      #1;
      exp_q.delete();
      acc_cnt = 0;
      popped  = 0;
      rst     = 1'b0;
   endtask

   // ---------------- directed and random sequence ----------------
   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 8'h00; in_alt = 1'b0;
      in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; out_ready = 1'b1;

      // ADD x3,x1,x2 right after reset, two-cycle latency
      do_reset();
      out_ready = 1'b1;
      send(8'h01, 1'b0, 5'd3, 5'd1, 5'd2);
      check("t1_lat_early", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_instr", 64'(out_instr), 64'h0000_0000_0020_81B3);
      check("t1_addr", 64'(out_addr), 64'(BASE));
      drain();

      // SUB, SRA, AND back-to-back on consecutive cycles
      do_reset();
      send(8'h01, 1'b1, 5'd3, 5'd1, 5'd2);
      send(8'h20, 1'b1, 5'd5, 5'd6, 5'd7);
      check("t2_sub_instr", 64'(out_instr), 64'h0000_0000_4020_81B3);
      check("t2_sub_addr", 64'(out_addr), 64'(BASE));
      send(8'h80, 1'b0, 5'd10, 5'd11, 5'd12);
      check("t2_sra_instr", 64'(out_instr), 64'h0000_0000_4073_52B3);
      check("t2_sra_addr", 64'(out_addr), 64'(BASE + 32'd4));
      @(posedge clk);
      #1;
      check("t2_and_valid", 64'(out_valid), 64'd1);
      check("t2_and_instr", 64'(out_instr), 64'h0000_0000_00C5_F533);
      check("t2_and_addr", 64'(out_addr), 64'(BASE + 32'd8));
      drain();

      // Three illegal requests, then a legal word still gets the base address
      do_reset();
      send(8'h03, 1'b0, 5'd1, 5'd2, 5'd3);
      send(8'h00, 1'b0, 5'd1, 5'd2, 5'd3);
      send(8'h10, 1'b1, 5'd1, 5'd2, 5'd3);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      check("t3_err_count", 64'(err_count), 64'd3);
      check("t3_no_valid", 64'(out_valid), 64'd0);
      send(8'h01, 1'b0, 5'd3, 5'd1, 5'd2);
      @(posedge clk);
      #1;
      check("t3_valid", 64'(out_valid), 64'd1);
      check("t3_addr", 64'(out_addr), 64'(BASE));
      drain();

      // Backpressure: two accepts fill both stages, then in_ready drops
      do_reset();
      out_ready = 1'b0;
      send_legal();
      send_legal();
      drive_req(8'h40, 1'b0, 5'd9, 5'd8, 5'd7);
      repeat (3) begin
         @(negedge clk);
         check("t4_in_ready_low", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_accept();
      repeat (4) send_legal();
      drain();

      // Address wrap with DEPTH=4: five words
      do_reset();
      out_ready = 1'b1;
      repeat (5) send_legal();
      drain();
      check("t5_wrapped", 64'(wrapped), 64'd1);

      // Reset with both stages full and a nonzero error count
      do_reset();
      send_illegal();
      out_ready = 1'b0;
      send_legal();
      send_legal();
      do_reset();
      out_ready = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      check("t6_quiet", 64'(out_valid), 64'd0);

      // Error counter saturates at 2**ERR_W-1
      repeat (9) send_illegal();
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("t7_err_sat", 64'(err_count), 64'd7);

      // Random mix of legal/illegal requests with random backpressure
      do_reset();
      rand_mode = 1'b1;
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0) send_illegal();
         else send_legal();
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
